// File: rtl/trace_pkg.sv
// Shared types for the trace port producer: the buffered record and emit FSM states.
package trace_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        rdv;
        logic [4:0]  rd;
        logic [31:0] rd_data;
        logic        pcv;
        logic [31:0] pc_x;
    } trace_rec_t;

    typedef enum logic {
        EMIT_IDLE  = 1'b0,
        EMIT_SPLIT = 1'b1
    } emit_state_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace records with a combinational head view.
// Storage is not reset; only pointers and occupancy are, so the head is
// meaningful only while empty is low.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  trace_rec_t               push_rec,
    input  logic                     pop,
    output trace_rec_t               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    trace_rec_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    // Guard against overflow/underflow so a misbehaving caller cannot corrupt state.
    assign do_push = push && (count_q != FULL_LVL);
    assign do_pop  = pop && (count_q != '0);

    // Record storage; written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_rec;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/trace_emitter.sv
// Trace port producer: normalises execute-stage events into records, buffers
// them, and emits one record per cycle, splitting link-write+redirect records.
module trace_emitter
    import trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    input  logic        in_rdv,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_rd_data,
    input  logic        in_pcv,
    input  logic [31:0] in_pc_x,
    output logic        stall,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        rdv,
    output logic [4:0]  rd_x,
    output logic [31:0] rd_data,
    output logic        pcv,
    output logic [31:0] pc_x,
    output logic [31:0] instret
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - 1);

    trace_rec_t    in_rec;
    trace_rec_t    head;
    trace_rec_t    out_d;
    trace_rec_t    out_q;
    logic [CW-1:0] count;
    logic          empty;
    logic          accept;
    logic          pop;
    emit_state_t   state_d;
    emit_state_t   state_q;
    logic [31:0]   instret_q;

    // Assemble the incoming record; writes to x0 carry no information.
    always_comb begin
        in_rec         = '0;
        in_rec.valid   = in_valid;
        in_rec.pc      = in_pc;
        in_rec.inst    = in_inst;
        in_rec.rdv     = in_rdv && (in_rd != 5'd0);
        in_rec.rd      = in_rd;
        in_rec.rd_data = in_rd_data;
        in_rec.pcv     = in_pcv;
        in_rec.pc_x    = in_pc_x;
    end

    // Stall leaves one slot of slack so the decision depends only on registered state.
    assign stall  = (count >= STALL_LVL);
    assign accept = !stall && (in_rec.valid || in_rec.rdv || in_rec.pcv);

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (accept),
        .push_rec (in_rec),
        .pop      (pop),
        .head     (head),
        .count    (count),
        .empty    (empty)
    );

    // Emit FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMIT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enter SPLIT only for a head carrying both a writeback and a redirect.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMIT_IDLE: begin
                if (!empty && head.rdv && head.pcv) begin
                    state_d = EMIT_SPLIT;
                end
            end
            EMIT_SPLIT: state_d = EMIT_IDLE;
            default:    state_d = EMIT_IDLE;
        endcase
    end

    // Output selection and pop; non-flagged fields keep their previous values.
    always_comb begin
        out_d       = out_q;
        out_d.valid = 1'b0;
        out_d.rdv   = 1'b0;
        out_d.pcv   = 1'b0;
        pop         = 1'b0;
        case (state_q)
            EMIT_IDLE: begin
                if (!empty) begin
                    if (head.rdv && head.pcv) begin
                        out_d.valid   = head.valid;
                        out_d.pc      = head.pc;
                        out_d.inst    = head.inst;
                        out_d.rdv     = 1'b1;
                        out_d.rd      = head.rd;
                        out_d.rd_data = head.rd_data;
                    end else begin
                        out_d = head;
                        pop   = 1'b1;
                    end
                end
            end
            EMIT_SPLIT: begin
                out_d.pcv  = 1'b1;
                out_d.pc_x = head.pc_x;
                pop        = 1'b1;
            end
            default: begin
                pop = 1'b0;
            end
        endcase
    end

    // Output registers and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q     <= '0;
            instret_q <= '0;
        end else begin
            out_q <= out_d;
            if (out_d.valid) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    assign valid   = out_q.valid;
    assign pc      = out_q.pc;
    assign inst    = out_q.inst;
    assign rdv     = out_q.rdv;
    assign rd_x    = out_q.rd;
    assign rd_data = out_q.rd_data;
    assign pcv     = out_q.pcv;
    assign pc_x    = out_q.pc_x;
    assign instret = instret_q;

endmodule

// File: tb/tb_trace_emitter.sv
// Directed testbench for trace_emitter (DEPTH=4).
module tb_trace_emitter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic        in_rdv = 1'b0;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_rd_data = '0;
    logic        in_pcv = 1'b0;
    logic [31:0] in_pc_x = '0;
    logic        stall;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rdv;
    logic [4:0]  rd_x;
    logic [31:0] rd_data;
    logic        pcv;
    logic [31:0] pc_x;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trace_emitter #(.DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_pc      (in_pc),
        .in_inst    (in_inst),
        .in_rdv     (in_rdv),
        .in_rd      (in_rd),
        .in_rd_data (in_rd_data),
        .in_pcv     (in_pcv),
        .in_pc_x    (in_pc_x),
        .stall      (stall),
        .valid      (valid),
        .pc         (pc),
        .inst       (inst),
        .rdv        (rdv),
        .rd_x       (rd_x),
        .rd_data    (rd_data),
        .pcv        (pcv),
        .pc_x       (pc_x),
        .instret    (instret)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] p, input logic [31:0] ins,
                         input logic wv, input logic [4:0] r, input logic [31:0] d,
                         input logic jv, input logic [31:0] px);
        in_valid = v; in_pc = p; in_inst = ins; in_rdv = wv;
        in_rd = r; in_rd_data = d; in_pcv = jv; in_pc_x = px;
    endtask

    task automatic idle_in();
        drive(1'b0, '0, '0, 1'b0, 5'd0, '0, 1'b0, '0);
    endtask

    logic [1:0]  ev_kind [$];
    logic [31:0] ev_val  [$];

    task automatic log_outputs();
        if (valid) begin ev_kind.push_back(2'd1); ev_val.push_back(pc); end
        if (pcv)   begin ev_kind.push_back(2'd2); ev_val.push_back(pc_x); end
    endtask

    initial begin
        int  i;
        int  cyc;
        bit  saw_stall;

        // ---- reset ----
        idle_in();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_rdv", {31'd0, rdv}, 32'd0);
        check("rst_pcv", {31'd0, pcv}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_pc", pc, 32'd0);

        // ---- single addi ----
        drive(1'b1, 32'h8000_0000, 32'h0050_0093, 1'b1, 5'd1, 32'd5, 1'b0, '0);
        tick();
        idle_in();
        check("addi_nobypass", {31'd0, valid}, 32'd0);
        tick();
        check("addi_valid", {31'd0, valid}, 32'd1);
        check("addi_pc", pc, 32'h8000_0000);
        check("addi_inst", inst, 32'h0050_0093);
        check("addi_rdv", {31'd0, rdv}, 32'd1);
        check("addi_rd", {27'd0, rd_x}, 32'd1);
        check("addi_data", rd_data, 32'd5);
        check("addi_pcv", {31'd0, pcv}, 32'd0);
        check("addi_instret", instret, 32'd1);
        tick();
        check("addi_drop", {31'd0, valid}, 32'd0);

        // ---- x0 suppression ----
        drive(1'b1, 32'h8000_0004, 32'h0000_0013, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, '0);
        tick();
        idle_in();
        tick();
        check("x0_valid", {31'd0, valid}, 32'd1);
        check("x0_rdv", {31'd0, rdv}, 32'd0);
        check("x0_pc", pc, 32'h8000_0004);
        check("x0_instret", instret, 32'd2);

        // ---- split jal x1 ----
        drive(1'b1, 32'h8000_0010, 32'h0F00_00EF, 1'b1, 5'd1, 32'h8000_0014, 1'b1, 32'h8000_0100);
        tick();
        idle_in();
        tick();
        check("split1_valid", {31'd0, valid}, 32'd1);
        check("split1_rdv", {31'd0, rdv}, 32'd1);
        check("split1_pcv", {31'd0, pcv}, 32'd0);
        check("split1_data", rd_data, 32'h8000_0014);
        check("split1_instret", instret, 32'd3);
        tick();
        check("split2_valid", {31'd0, valid}, 32'd0);
        check("split2_rdv", {31'd0, rdv}, 32'd0);
        check("split2_pcv", {31'd0, pcv}, 32'd1);
        check("split2_pcx", pc_x, 32'h8000_0100);
        check("split2_instret", instret, 32'd3);
        tick();
        check("split3_pcv", {31'd0, pcv}, 32'd0);

        // ---- backpressure: 6 split records ----
        ev_kind.delete(); ev_val.delete();
        i = 0; saw_stall = 1'b0;
        for (cyc = 0; cyc < 80 && !(i == 6 && ev_kind.size() == 12); cyc++) begin
            bit will_accept;
            if (i < 6)
                drive(1'b1, 32'h8000_0200 + 32'(i * 4), 32'h0000_006F, 1'b1, 5'd1,
                      32'h8000_0204 + 32'(i * 4), 1'b1, 32'h8000_1000 + 32'(i * 16));
            else
                idle_in();
            if (stall) saw_stall = 1'b1;
            will_accept = (i < 6) && !stall;
            tick();
            if (will_accept) i++;
            check("bp_exclusive", {31'd0, valid & pcv}, 32'd0);
            log_outputs();
        end
        idle_in();
        check("bp_saw_stall", {31'd0, saw_stall}, 32'd1);
        check("bp_accepted", 32'(i), 32'd6);
        check("bp_events", 32'(ev_kind.size()), 32'd12);
        for (int k = 0; k < 6; k++) begin
            if (ev_kind.size() >= 2 * k + 2) begin
                check("bp_kind_retire", {30'd0, ev_kind[2*k]}, 32'd1);
                check("bp_retire_pc", ev_val[2*k], 32'h8000_0200 + 32'(k * 4));
                check("bp_kind_redirect", {30'd0, ev_kind[2*k+1]}, 32'd2);
                check("bp_redirect_pcx", ev_val[2*k+1], 32'h8000_1000 + 32'(k * 16));
            end
        end
        check("bp_instret", instret, 32'd9);
        check("bp_stall_clear", {31'd0, stall}, 32'd0);

        // ---- wrap: 9 single records after a fresh reset ----
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("wrap_rst_instret", instret, 32'd0);
        ev_kind.delete(); ev_val.delete();
        i = 0;
        for (cyc = 0; cyc < 80 && !(i == 9 && ev_kind.size() == 9); cyc++) begin
            bit will_accept;
            if (i < 9)
                drive(1'b1, 32'h9000_0000 + 32'(i * 4), 32'(i), 1'b0, 5'd0, '0, 1'b0, '0);
            else
                idle_in();
            will_accept = (i < 9) && !stall;
            tick();
            if (will_accept) i++;
            log_outputs();
        end
        idle_in();
        check("wrap_events", 32'(ev_kind.size()), 32'd9);
        for (int k = 0; k < 9; k++) begin
            if (ev_kind.size() > k) begin
                check("wrap_pc", ev_val[k], 32'h9000_0000 + 32'(k * 4));
            end
        end
        check("wrap_instret", instret, 32'd9);

        // ---- reset mid-SPLIT with 2 queued ----
        drive(1'b1, 32'hA000_0000, 32'h0000_006F, 1'b1, 5'd1, 32'hA000_0004, 1'b1, 32'hA000_1000);
        tick();
        drive(1'b1, 32'hA000_0004, 32'h0000_006F, 1'b1, 5'd1, 32'hA000_0008, 1'b1, 32'hA000_2000);
        tick();
        idle_in();
        check("mid_first_half", {31'd0, valid & rdv}, 32'd1);
        check("mid_instret", instret, 32'd10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_valid", {31'd0, valid}, 32'd0);
        check("mid_rdv", {31'd0, rdv}, 32'd0);
        check("mid_pcv", {31'd0, pcv}, 32'd0);
        check("mid_pcx", pc_x, 32'd0);
        check("mid_instret0", instret, 32'd0);
        check("mid_stall", {31'd0, stall}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("post_rst_quiet", {30'd0, valid, pcv}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
